// File: rtl/ptp_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ptp_load_scheduler
// Description : Round-robin scheduler in front of a single load-enable holding
//               register. It picks one pending requester, pulses the
//               register's load enable with that requester's word, acks the
//               requester, and then offers the held word to one consumer over
//               a valid/ready handshake. An optional timeout drops words that
//               the consumer never takes.
//
// Ports:
//   clk          in   system clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   req_valid    in   [NUM_REQ]            per-requester word pending
//   req_data     in   [NUM_REQ*(NUM_BITS+1)] packed requester words
//   req_ack      out  [NUM_REQ]            one-hot pulse, word captured
//   load_enable  out                       holding-register load strobe
//   load_data    out  [NUM_BITS+1]         holding-register data input
//   out_valid    out                       held word offered to consumer
//   out_ready    in                        consumer accepts the word
//   grant_id     out  [clog2(NUM_REQ)]     source of current/last word
//   busy         out                       scheduler not idle
//   err_timeout  out                       pulse, word dropped on timeout
//
// Revision    : 1.0 - initial release
// ============================================================================
module ptp_load_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 11,
  parameter int TIMEOUT  = 0
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*(NUM_BITS+1)-1:0]   req_data,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic                              load_enable,
  output logic [NUM_BITS:0]                 load_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              busy,
  output logic                              err_timeout
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int WORD_W = NUM_BITS + 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Counter value at which the word in VALID is considered expired.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  to_cnt;

  logic              arb_found;
  logic [ID_W-1:0]   arb_idx;
  logic              take_grant;
  logic              cnt_inc;
  logic              expire;

  // --------------------------------------------------------------------------
  // Round-robin arbitration. First pass looks only above the pointer, the
  // second pass (which only matters if the first found nothing) covers the
  // wrap-around from index 0 up to and including the pointer.
  // --------------------------------------------------------------------------
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req_valid[i] && (i > int'(rr_ptr))) begin
        arb_found = 1'b1;
        arb_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req_valid[i]) begin
        arb_found = 1'b1;
        arb_idx   = ID_W'(i);
      end
    end
  end

  assign expire = (TIMEOUT > 0) && (to_cnt == TO_LAST);

  // --------------------------------------------------------------------------
  // State and bookkeeping registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      grant_id <= '0;
      to_cnt   <= '0;
    end else begin
      state <= state_next;
      if (take_grant) begin
        grant_id <= arb_idx;
        rr_ptr   <= arb_idx;
      end
      if (state == LOAD) begin
        to_cnt <= '0;
      end else if (cnt_inc) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    take_grant  = 1'b0;
    cnt_inc     = 1'b0;
    req_ack     = '0;
    load_enable = 1'b0;
    load_data   = '0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    err_timeout = 1'b0;

    case (state)
      IDLE: begin
        if (arb_found) begin
          take_grant = 1'b1;
          state_next = LOAD;
        end
      end

      LOAD: begin
        busy              = 1'b1;
        load_enable       = 1'b1;
        load_data         = req_data[int'(grant_id)*WORD_W +: WORD_W];
        req_ack[grant_id] = 1'b1;
        state_next        = VALID;
      end

      VALID: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // A handshake in the expiry cycle takes precedence over the drop.
        if (out_ready || expire) begin
          err_timeout = !out_ready;
          if (arb_found) begin
            take_grant = 1'b1;
            state_next = LOAD;
          end else begin
            state_next = IDLE;
          end
        end else if (TIMEOUT > 0) begin
          cnt_inc = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ptp_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ptp_load_scheduler
// Description : Directed self-checking bench for ptp_load_scheduler. Two
//               instances share stimulus: one with an 8-cycle timeout and one
//               with the timeout disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ptp_load_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int NUM_BITS = 11;
  localparam int WORD_W   = NUM_BITS + 1;
  localparam int ID_W     = $clog2(NUM_REQ);

  logic                            clk = 1'b0;
  logic                            n_rst;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*WORD_W-1:0]       req_data;
  logic                            out_ready;

  logic [NUM_REQ-1:0]  to_req_ack,     nt_req_ack;
  logic                to_load_enable, nt_load_enable;
  logic [NUM_BITS:0]   to_load_data,   nt_load_data;
  logic                to_out_valid,   nt_out_valid;
  logic [ID_W-1:0]     to_grant_id,    nt_grant_id;
  logic                to_busy,        nt_busy;
  logic                to_err_timeout, nt_err_timeout;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] words [NUM_REQ] = '{12'h111, 12'h222, 12'hABC, 12'h333};

  always #5 clk = ~clk;

  ptp_load_scheduler #(.NUM_REQ(NUM_REQ), .NUM_BITS(NUM_BITS), .TIMEOUT(8)) dut_to (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(to_req_ack), .load_enable(to_load_enable), .load_data(to_load_data),
    .out_valid(to_out_valid), .out_ready(out_ready), .grant_id(to_grant_id),
    .busy(to_busy), .err_timeout(to_err_timeout)
  );

  ptp_load_scheduler #(.NUM_REQ(NUM_REQ), .NUM_BITS(NUM_BITS), .TIMEOUT(0)) dut_nt (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(nt_req_ack), .load_enable(nt_load_enable), .load_data(nt_load_data),
    .out_valid(nt_out_valid), .out_ready(out_ready), .grant_id(nt_grant_id),
    .busy(nt_busy), .err_timeout(nt_err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_duts();
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Both instances must show the same LOAD cycle for requester idx.
  task automatic check_load(input string tag, input int idx);
    check({tag, " to load_enable"}, to_load_enable, 1);
    check({tag, " to load_data"},   to_load_data,   words[idx]);
    check({tag, " to req_ack"},     to_req_ack,     32'(1) << idx);
    check({tag, " to grant_id"},    to_grant_id,    idx);
    check({tag, " to busy"},        to_busy,        1);
    check({tag, " to out_valid"},   to_out_valid,   0);
    check({tag, " nt load_enable"}, nt_load_enable, 1);
    check({tag, " nt load_data"},   nt_load_data,   words[idx]);
    check({tag, " nt req_ack"},     nt_req_ack,     32'(1) << idx);
    check({tag, " nt grant_id"},    nt_grant_id,    idx);
  endtask

  initial begin
    n_rst     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WORD_W +: WORD_W] = words[i];

    // Reset state, before any clock edge.
    #1;
    check("rst to out_valid",   to_out_valid,   0);
    check("rst to load_enable", to_load_enable, 0);
    check("rst to load_data",   to_load_data,   0);
    check("rst to req_ack",     to_req_ack,     0);
    check("rst to grant_id",    to_grant_id,    0);
    check("rst to busy",        to_busy,        0);
    check("rst to err_timeout", to_err_timeout, 0);
    check("rst nt busy",        nt_busy,        0);
    @(negedge clk);
    n_rst = 1'b1;

    // Single request from requester 2.
    req_valid = 4'b0100;
    out_ready = 1'b1;
    @(negedge clk);
    check_load("single", 2);
    req_valid = '0;
    @(negedge clk);
    check("single valid out_valid",   to_out_valid,   1);
    check("single valid load_enable", to_load_enable, 0);
    check("single valid load_data",   to_load_data,   0);
    check("single valid req_ack",     to_req_ack,     0);
    check("single valid busy",        to_busy,        1);
    @(negedge clk);
    check("single idle out_valid", to_out_valid, 0);
    check("single idle busy",      to_busy,      0);
    check("single idle grant_id",  to_grant_id,  2);

    // Fairness: all requesters pending, consumer always ready.
    reset_duts();
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_load("fair", i % 4);
      @(negedge clk);
      check("fair valid load_enable", to_load_enable, 0);
      check("fair valid out_valid",   to_out_valid,   1);
      check("fair valid busy",        to_busy,        1);
      if (i == 5) req_valid = '0;
    end
    @(negedge clk);
    check("fair end busy", to_busy, 0);

    // Backpressure: timeout instance drops after 8 cycles, other holds.
    reset_duts();
    req_valid = 4'b0001;
    out_ready = 1'b0;
    @(negedge clk);
    check_load("bp", 0);
    req_valid = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("bp to out_valid",   to_out_valid,   1);
      check("bp to err_timeout", to_err_timeout, (k == 8) ? 1 : 0);
      check("bp nt out_valid",   nt_out_valid,   1);
      check("bp nt err_timeout", nt_err_timeout, 0);
    end
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      check("hold to out_valid",   to_out_valid,   0);
      check("hold to busy",        to_busy,        0);
      check("hold to err_timeout", to_err_timeout, 0);
      check("hold nt out_valid",   nt_out_valid,   1);
      check("hold nt err_timeout", nt_err_timeout, 0);
      check("hold nt req_ack",     nt_req_ack,     0);
    end

    // Race: ready arrives in the expiry cycle, handshake wins.
    reset_duts();
    req_valid = 4'b0100;
    out_ready = 1'b0;
    @(negedge clk);
    check_load("race", 2);
    req_valid = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("race wait out_valid",   to_out_valid,   1);
      check("race wait err_timeout", to_err_timeout, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("race hs out_valid",   to_out_valid,   1);
    check("race hs err_timeout", to_err_timeout, 0);
    @(negedge clk);
    check("race idle out_valid",   to_out_valid,   0);
    check("race idle busy",        to_busy,        0);
    check("race idle err_timeout", to_err_timeout, 0);

    // Asynchronous reset in the middle of a LOAD cycle.
    out_ready = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    check_load("arst pre", 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst load_enable", to_load_enable, 0);
    check("arst req_ack",     to_req_ack,     0);
    check("arst busy",        to_busy,        0);
    check("arst grant_id",    to_grant_id,    0);
    check("arst out_valid",   to_out_valid,   0);
    check("arst nt busy",     nt_busy,        0);
    req_valid = 4'b1111;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_load("arst post", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ptp_load_scheduler.md
Name: ptp_load_scheduler

Overview:
- Round-robin scheduler that shares one parallel-to-parallel holding register (load-enable, NUM_BITS+1 wide) between NUM_REQ requesters.
- Selects a requester and drives the register's load enable and data input for one cycle.
- Acknowledges the requester, then presents the held word to a single consumer with a valid/ready handshake.
- Optional timeout discards words the consumer never accepts.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_BITS, 11, MSB index of a word; word width is NUM_BITS+1.
- TIMEOUT, 0, cycles out_valid may stay unaccepted before the word is dropped; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester word pending; held high until acked.
- req_data  input  NUM_REQ*(NUM_BITS+1)  packed words; requester i occupies bits [i*(NUM_BITS+1) +: NUM_BITS+1].
- req_ack  output  NUM_REQ  one-hot, one-cycle pulse: word i captured.
- load_enable  output  1  shift_enable to the holding register.
- load_data  output  NUM_BITS+1  data_in to the holding register.
- out_valid  output  1  holding register contents valid for the consumer.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
- grant_id  output  clog2(NUM_REQ)  source index of the current or last loaded word.
- busy  output  1  state is not IDLE.
- err_timeout  output  1  one-cycle pulse: word dropped on timeout.

Behaviour:
- States: IDLE, LOAD, VALID. Registered state, grant_id, rr pointer (last granted index) and timeout counter.
- Reset (async, n_rst=0):
  - state=IDLE, rr pointer=NUM_REQ-1 (so requester 0 has first priority), grant_id=0, counter=0.
  - All outputs 0. The effect is immediate; no clock is needed.
- Arbitration (combinational): search req_valid starting at pointer+1 and wrap modulo NUM_REQ; first set bit wins. Used only in IDLE and in a VALID handshake/timeout cycle.
- IDLE:
  - If any req_valid is set: register the winner into grant_id and the pointer, then go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - load_enable=1; load_data=req_data slice[grant_id]; req_ack[grant_id]=1.
  - Go to VALID; clear the counter.
- VALID:
  - out_valid=1.
  - On out_ready=1 (handshake): if any req_valid is set, arbitrate and go directly to LOAD (back-to-back); otherwise go to IDLE.
  - If TIMEOUT>0 and out_ready=0: increment the counter each cycle. In the cycle the counter equals TIMEOUT-1, pulse err_timeout, drop the word, then arbitrate and leave VALID as on a handshake.
  - If out_ready and expiry fall in the same cycle, the handshake wins; no err_timeout.
- Latency: req_valid seen in IDLE at cycle N → LOAD at N+1 → out_valid at N+2. The register captures at the end of N+1.
- Throughput: at most one word every 2 cycles.
- Outside LOAD: load_enable=0, load_data=0, req_ack=0.
- A requester dropping req_valid before its ack is a protocol violation. The load still occurs with the current req_data; this is not checked.
- Only the granted requester's data is used. New requests arriving during LOAD/VALID wait for the next arbitration.
- busy=1 in LOAD and VALID.

Test Plan:
- Single request: req_valid=4'b0100 with slice 2=12'hABC in IDLE → next cycle load_enable=1, load_data=12'hABC, req_ack=4'b0100, grant_id=2; the following cycle out_valid=1.
- Fairness: all four req_valid held high, out_ready=1 → grant_id sequence 0,1,2,3,0,1; a load_enable pulse every 2 cycles; busy stays 1.
- Backpressure with TIMEOUT=8, out_ready=0 → out_valid high 8 cycles, err_timeout pulse on the 8th, then IDLE (no requests) with out_valid=0.
- Race with TIMEOUT=8: out_ready raised in the 8th VALID cycle → handshake accepted, err_timeout stays 0.
- Reset during LOAD: n_rst low mid-cycle → load_enable, req_ack, busy go to 0 immediately. After release with req_valid=4'b1111, first grant_id=0.
- TIMEOUT=0, out_ready=0 for 1000 cycles → out_valid held, err_timeout never asserts, no further req_ack.
